// File: rtl/led_shift_pkg.sv
// Shared definitions for the LED pattern engine.
//   MODE_*  : encodings of the 2-bit step-mode input.
//   DIR_*   : encodings of the bounce direction flag.
package led_shift_pkg;

  localparam logic [1:0] MODE_ROT_L   = 2'd0;
  localparam logic [1:0] MODE_ROT_R   = 2'd1;
  localparam logic [1:0] MODE_BOUNCE  = 2'd2;
  localparam logic [1:0] MODE_JOHNSON = 2'd3;

  localparam logic DIR_LEFT  = 1'b0;  // toward the MSB
  localparam logic DIR_RIGHT = 1'b1;  // toward the LSB

endpackage

// File: rtl/tick_divider.sv
// Step-rate divider. It counts enabled cycles and emits a registered
// one-cycle strobe on every DIV-th one.
//   clock  : system clock
//   rst    : synchronous active-high reset (count and strobe to 0)
//   enable : 1 = count, 0 = hold the count with the strobe low
//   clear  : synchronous restart of the period; drops any pending strobe
//   tick   : registered single-cycle strobe
module tick_divider #(
  parameter int DIV = 12000
) (
  input  logic clock,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  if (DIV < 2) begin : g_bad_div
    $error("tick_divider: DIV must be at least 2");
  end

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state is written with non-blocking assignments, so every
  // register samples the values from before the edge and process order does
  // not matter.
  always_ff @(posedge clock) begin
    if (rst || clear) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (enable) begin
      if (cnt == LAST) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + 1'b1;
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/led_shift_array.sv
// LED pattern engine. A tick divider sets the step rate. The N_LEDS-bit
// pattern advances once per tick by rotate-left, rotate-right, bounce, or
// Johnson fill.
//   clock        : system clock
//   rst          : synchronous active-high reset, highest priority
//   enable       : 1 = divider counts and the pattern advances, 0 = freeze
//   mode         : step mode (see led_shift_pkg MODE_*)
//   load         : single-cycle pattern load; also restarts the tick period
//   load_pattern : value captured when load=1
//   leds         : current pattern (registered)
//   tick         : registered one-cycle step strobe
//   dir          : bounce direction (0 = toward MSB, 1 = toward LSB)
module led_shift_array
  import led_shift_pkg::*;
#(
  parameter int CLK_FREQ = 12000000,
  parameter int TICK_HZ  = 1000,
  parameter int N_LEDS   = 8,
  parameter logic [N_LEDS-1:0] RESET_PATTERN = {{(N_LEDS-1){1'b0}}, 1'b1}
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic              load,
  input  logic [N_LEDS-1:0] load_pattern,
  output logic [N_LEDS-1:0] leds,
  output logic              tick,
  output logic              dir
);

  localparam int DIV = CLK_FREQ / TICK_HZ;

  if (N_LEDS < 2) begin : g_bad_width
    $error("led_shift_array: N_LEDS must be at least 2");
  end

  tick_divider #(
    .DIV (DIV)
  ) u_div (
    .clock  (clock),
    .rst    (rst),
    .enable (enable),
    .clear  (load),
    .tick   (tick)
  );

  logic [N_LEDS-1:0] step_leds;
  logic              step_dir;

  // NOTE: every signal written in an always_comb gets a default first, so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    step_leds = leds;
    step_dir  = dir;
    case (mode)
      MODE_ROT_L: step_leds = {leds[N_LEDS-2:0], leds[N_LEDS-1]};
      MODE_ROT_R: step_leds = {leds[0], leds[N_LEDS-1:1]};
      MODE_BOUNCE: begin
        // At an end of the bank the direction turns and the shift goes the
        // new way in the same step, so the lit bit never leaves the bank.
        if (dir == DIR_LEFT && leds[N_LEDS-1]) begin
          step_dir  = DIR_RIGHT;
          step_leds = leds >> 1;
        end else if (dir == DIR_RIGHT && leds[0]) begin
          step_dir  = DIR_LEFT;
          step_leds = leds << 1;
        end else if (dir == DIR_LEFT) begin
          step_leds = leds << 1;
        end else begin
          step_leds = leds >> 1;
        end
      end
      MODE_JOHNSON: step_leds = {leds[N_LEDS-2:0], ~leds[N_LEDS-1]};
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      leds <= RESET_PATTERN;
      dir  <= DIR_LEFT;
    end else if (load) begin
      leds <= load_pattern;
      dir  <= DIR_LEFT;
    end else if (tick && enable) begin
      leds <= step_leds;
      dir  <= step_dir;
    end
  end

endmodule

// File: tb/tb_led_shift_array.sv
// Self-checking bench for led_shift_array (DIV=4, 8 LEDs, reset pattern 01).
// A driver sets the inputs on the falling edge and advances a reference model
// of the engine. It pushes the expected post-edge outputs into a queue, and a
// monitor pops and compares each entry just after the rising edge. Directed
// scenarios also compare the outputs with hand-derived constants.
module tb_led_shift_array;

  localparam int CLK_FREQ = 8;
  localparam int TICK_HZ  = 2;
  localparam int DIV      = CLK_FREQ / TICK_HZ;
  localparam int N        = 8;

  logic         clock = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic         load = 1'b0;
  logic [N-1:0] load_pattern = '0;
  logic [N-1:0] leds;
  logic         tick;
  logic         dir;

  led_shift_array #(
    .CLK_FREQ      (CLK_FREQ),
    .TICK_HZ       (TICK_HZ),
    .N_LEDS        (N),
    .RESET_PATTERN (8'h01)
  ) dut (
    .clock        (clock),
    .rst          (rst),
    .enable       (enable),
    .mode         (mode),
    .load         (load),
    .load_pattern (load_pattern),
    .leds         (leds),
    .tick         (tick),
    .dir          (dir)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pattern and direction, the count of enabled cycles since
  // the last reset or load, and whether a step strobe is currently showing.
  typedef struct packed {
    logic [N-1:0] leds;
    logic         tick;
    logic         dir;
  } exp_t;

  exp_t   exp_q[$];
  int     m_leds;
  int     m_dir;
  int     m_tick;
  int     m_enabled;

  // One step of the pattern rules with plain integer arithmetic.
  function automatic void model_step(input int md, inout int v, inout int d);
    int mask = (1 << N) - 1;
    int msb  = (v >> (N - 1)) & 1;
    int lsb  = v & 1;
    case (md)
      0: v = ((v << 1) | msb) & mask;
      1: v = (v >> 1) | (lsb << (N - 1));
      2: begin
        if (d == 0 && msb == 1) d = 1;
        else if (d == 1 && lsb == 1) d = 0;
        v = (d == 0) ? ((v << 1) & mask) : (v >> 1);
      end
      default: v = ((v << 1) & mask) | (msb ^ 1);
    endcase
  endfunction

  // Drive one clock cycle of inputs and record what the DUT must show after it.
  task automatic cycle(input logic r, input logic e, input logic [1:0] md,
                       input logic l, input logic [N-1:0] pat);
    @(negedge clock);
    rst = r; enable = e; mode = md; load = l; load_pattern = pat;
    if (r) begin
      m_leds = 1; m_dir = 0; m_tick = 0; m_enabled = 0;
    end else if (l) begin
      m_leds = int'(pat); m_dir = 0; m_tick = 0; m_enabled = 0;
    end else begin
      if (m_tick == 1 && e) model_step(int'(md), m_leds, m_dir);
      if (e) begin
        m_enabled++;
        m_tick = (m_enabled % DIV == 0) ? 1 : 0;
      end else begin
        m_tick = 0;
      end
    end
    exp_q.push_back('{leds: m_leds[N-1:0], tick: m_tick[0], dir: m_dir[0]});
  endtask

  task automatic run(input int n, input logic e, input logic [1:0] md);
    for (int i = 0; i < n; i++) cycle(1'b0, e, md, 1'b0, '0);
  endtask

  // Wait for the edge that applies the last driven inputs, then step clear of it.
  task automatic settle();
    @(posedge clock);
    #2;
  endtask

  // Monitor: every cycle with a queued expectation is compared.
  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("sb_leds", 32'(leds), 32'(e.leds));
      check("sb_tick", 32'(tick), 32'(e.tick));
      check("sb_dir",  32'(dir),  32'(e.dir));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state, ROT_L tick timing and a full rotation, then ROT_R.
    cycle(1'b1, 1'b0, 2'd0, 1'b0, '0);
    settle();
    check("reset_leds", 32'(leds), 32'h01);
    check("reset_tick", 32'(tick), 32'h0);
    check("reset_dir",  32'(dir),  32'h0);
    run(3, 1'b1, 2'd0);
    settle();
    check("rotl_no_tick_c3", 32'(tick), 32'h0);
    run(1, 1'b1, 2'd0);
    settle();
    check("rotl_tick_c4", 32'(tick), 32'h1);
    check("rotl_leds_c4", 32'(leds), 32'h01);
    run(4, 1'b1, 2'd0);
    settle();
    check("rotl_first_step", 32'(leds), 32'h02);
    run(28, 1'b1, 2'd0);
    settle();
    check("rotl_wrap", 32'(leds), 32'h01);

    cycle(1'b1, 1'b0, 2'd1, 1'b0, '0);
    run(5, 1'b1, 2'd1);
    settle();
    check("rotr_first_step", 32'(leds), 32'h80);

    // 2: bounce from 01 returns to 01 (heading right) after 14 steps.
    cycle(1'b1, 1'b0, 2'd2, 1'b0, '0);
    run(32, 1'b1, 2'd2);
    settle();
    check("bounce_top", 32'(leds), 32'h80);
    check("bounce_top_dir", 32'(dir), 32'h0);
    run(4, 1'b1, 2'd2);
    settle();
    check("bounce_turn", 32'(leds), 32'h40);
    check("bounce_turn_dir", 32'(dir), 32'h1);
    run(24, 1'b1, 2'd2);
    settle();
    check("bounce_bottom", 32'(leds), 32'h01);
    check("bounce_bottom_dir", 32'(dir), 32'h1);
    run(4, 1'b1, 2'd2);
    settle();
    check("bounce_restart", 32'(leds), 32'h02);
    check("bounce_restart_dir", 32'(dir), 32'h0);

    // 3: Johnson fill from 00: FF after 8 steps, 00 after 16.
    cycle(1'b0, 1'b1, 2'd3, 1'b1, 8'h00);
    run(36, 1'b1, 2'd3);
    settle();
    check("johnson_full", 32'(leds), 32'hFF);
    run(32, 1'b1, 2'd3);
    settle();
    check("johnson_period", 32'(leds), 32'h00);

    // 4: load A5 in the cycle cnt==3 discards the pending tick.
    cycle(1'b1, 1'b0, 2'd0, 1'b0, '0);
    run(3, 1'b1, 2'd0);
    cycle(1'b0, 1'b1, 2'd0, 1'b1, 8'hA5);
    settle();
    check("load_leds", 32'(leds), 32'hA5);
    check("load_tick", 32'(tick), 32'h0);
    run(3, 1'b1, 2'd0);
    settle();
    check("load_no_tick_c3", 32'(tick), 32'h0);
    run(1, 1'b1, 2'd0);
    settle();
    check("load_tick_c4", 32'(tick), 32'h1);
    check("load_hold_leds", 32'(leds), 32'hA5);
    run(1, 1'b1, 2'd0);
    settle();
    check("load_rotl", 32'(leds), 32'h4B);

    // 5: freeze at cnt==2 for 10 cycles, then the tick comes 2 cycles later.
    cycle(1'b1, 1'b0, 2'd0, 1'b0, '0);
    run(2, 1'b1, 2'd0);
    for (int i = 0; i < 10; i++) begin
      run(1, 1'b0, 2'd0);
      settle();
      check("freeze_tick", 32'(tick), 32'h0);
    end
    check("freeze_leds", 32'(leds), 32'h01);
    run(1, 1'b1, 2'd0);
    settle();
    check("resume_no_tick", 32'(tick), 32'h0);
    run(1, 1'b1, 2'd0);
    settle();
    check("resume_tick", 32'(tick), 32'h1);

    // 6: reset with load mid-bounce while heading right.
    cycle(1'b1, 1'b0, 2'd2, 1'b0, '0);
    run(38, 1'b1, 2'd2);
    settle();
    check("pre_reset_dir", 32'(dir), 32'h1);
    cycle(1'b1, 1'b1, 2'd2, 1'b1, 8'hFF);
    settle();
    check("rst_load_leds", 32'(leds), 32'h01);
    check("rst_load_dir",  32'(dir),  32'h0);
    check("rst_load_tick", 32'(tick), 32'h0);

    // Random traffic against the model.
    begin
      logic [1:0] md = 2'd0;
      for (int i = 0; i < 800; i++) begin
        if ($urandom_range(7) == 0) md = 2'($urandom_range(3));
        cycle($urandom_range(63) == 0,
              $urandom_range(3) != 0,
              md,
              $urandom_range(23) == 0,
              8'($urandom));
      end
    end

    begin
      int guard = 0;
      while (exp_q.size() > 0 && guard < 20) begin
        @(negedge clock);
        guard++;
      end
      check("queue_drained", 32'(exp_q.size()), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
